// File: rtl/mux_scan_74151_n.sv
// mux_scan_74151_n: registered 74151-style N:1 data selector with round-robin scan,
// channel enable mask, valid/ready output handshake and scan wrap marker.
module mux_scan_74151_n #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      strobe_n,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS-1:0]       chan_en,
    input  logic [CHANNELS*WIDTH-1:0] d,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          y,
    output logic [WIDTH-1:0]          w,
    output logic                      y_valid,
    output logic [SEL_W-1:0]          y_ch,
    output logic                      scan_wrap,
    output logic                      sel_err
);
    typedef enum logic [1:0] {IDLE, DIRECT, SCAN} stateT;
    localparam logic [SEL_W:0] NCH = (SEL_W+1)'(CHANNELS);

    stateT state, stateNext, stateD;
    logic [SEL_W-1:0] ptr, ptrD, yChD, base, hit;
    logic [WIDTH-1:0] yD;
    logic validD, wrapD, selErrD, primed, primedD, found, lo;
    logic [SEL_W:0] sum, hitP1;
    logic [WIDTH-1:0] chanData [2**SEL_W];
    logic [2**SEL_W-1:0] enExt;

    // Pad the channel table to a power of two so any sel/ptr value indexes safely.
    genvar g;
    for (g = 0; g < 2**SEL_W; g++) begin : gCh
        if (g < CHANNELS) begin : gReal
            assign chanData[g] = d[g*WIDTH +: WIDTH];
            assign enExt[g]    = chan_en[g];
        end else begin : gPad
            assign chanData[g] = '0;
            assign enExt[g]    = 1'b0;
        end
    end

    always_comb begin
        lo        = !y_valid || out_ready;
        stateNext = strobe_n ? IDLE : (mode ? SCAN : DIRECT);
        base      = (state == SCAN) ? ptr : '0;
        found     = 1'b0;
        hit       = '0;
        sum       = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            sum = {1'b0, base} + (SEL_W+1)'(k);
            if (sum >= NCH) sum = sum - NCH;
            if (!found && enExt[sum[SEL_W-1:0]]) begin
                found = 1'b1;
                hit   = sum[SEL_W-1:0];
            end
        end
        hitP1   = {1'b0, hit} + (SEL_W+1)'(1);
        stateD  = lo ? stateNext : state;
        ptrD    = ptr;
        yD      = y;
        yChD    = y_ch;
        validD  = y_valid;
        wrapD   = scan_wrap;
        selErrD = 1'b0;
        primedD = primed;
        if (lo) begin
            if (stateNext == IDLE) begin
                yD      = '0;
                validD  = 1'b0;
                wrapD   = 1'b0;
                primedD = 1'b0;
            end else if (stateNext == DIRECT) begin
                yD      = ({1'b0, sel} < NCH) ? chanData[sel] : '0;
                yChD    = ({1'b0, sel} < NCH) ? sel : y_ch;
                validD  = {1'b0, sel} < NCH;
                selErrD = {1'b0, sel} >= NCH;
                wrapD   = 1'b0;
                primedD = 1'b0;
            end else begin
                // A hit at or below the previous sample index means the pass restarted.
                yD      = found ? chanData[hit] : '0;
                yChD    = found ? hit : y_ch;
                validD  = found;
                wrapD   = found && primed && (hit <= y_ch);
                ptrD    = found ? ((hitP1 == NCH) ? '0 : hitP1[SEL_W-1:0]) : base;
                primedD = primed || found;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            y         <= '0;
            w         <= '1;
            y_valid   <= 1'b0;
            y_ch      <= '0;
            scan_wrap <= 1'b0;
            sel_err   <= 1'b0;
            primed    <= 1'b0;
        end else begin
            state     <= stateD;
            ptr       <= ptrD;
            y         <= yD;
            w         <= ~yD;
            y_valid   <= validD;
            y_ch      <= yChD;
            scan_wrap <= wrapD;
            sel_err   <= selErrD;
            primed    <= primedD;
        end
    end
endmodule

// File: tb/tb_mux_scan_74151_n.sv
// tb_mux_scan_74151_n: directed bench for the 8-channel selector plus a 6-channel
// instance for out-of-range select and non-power-of-two scan wrap.
module tb_mux_scan_74151_n;
    logic clk = 0, reset = 0, strobe_n = 1, mode = 0, out_ready = 1;
    logic [2:0] sel = 0;
    logic [7:0] chan_en = 0;
    logic [5:0] chanEn6 = 0;
    logic [63:0] d;
    logic [47:0] d6;
    logic [7:0] y, w, y6, w6, ey;
    logic [2:0] yCh, yCh6;
    logic yValid, scanWrap, selErr, yValid6, scanWrap6, selErr6;
    logic [21:0] exp;
    int cmp = 0, bad = 0;

    mux_scan_74151_n #(.WIDTH(8), .CHANNELS(8), .SEL_W(3)) dut (
        .clk(clk), .reset(reset), .strobe_n(strobe_n), .mode(mode), .sel(sel),
        .chan_en(chan_en), .d(d), .out_ready(out_ready), .y(y), .w(w),
        .y_valid(yValid), .y_ch(yCh), .scan_wrap(scanWrap), .sel_err(selErr));

    mux_scan_74151_n #(.WIDTH(8), .CHANNELS(6), .SEL_W(3)) dut6 (
        .clk(clk), .reset(reset), .strobe_n(strobe_n), .mode(mode), .sel(sel),
        .chan_en(chanEn6), .d(d6), .out_ready(out_ready), .y(y6), .w(w6),
        .y_valid(yValid6), .y_ch(yCh6), .scan_wrap(scanWrap6), .sel_err(selErr6));

    wire [21:0] obs  = {y, w, yValid, yCh, scanWrap, selErr};
    wire [21:0] obs6 = {y6, w6, yValid6, yCh6, scanWrap6, selErr6};

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #1 reset = 1;
        #1;
        cmp++;
        if (obs !== {8'h00, 8'hFF, 1'b0, 3'd0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_init: got %h want %h", obs, {8'h00, 8'hFF, 1'b0, 3'd0, 1'b0, 1'b0});
        end
        @(negedge clk) reset = 0;
    endtask

    task automatic test_direct;
        strobe_n = 0; mode = 0; sel = 3; out_ready = 1;
        tick;
        cmp++;
        if (obs !== {8'hA5, 8'h5A, 1'b1, 3'd3, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL direct_sel3: got %h want %h", obs, {8'hA5, 8'h5A, 1'b1, 3'd3, 1'b0, 1'b0});
        end
        sel = 6;
        tick;
        cmp++;
        if (obs !== {8'h16, 8'hE9, 1'b1, 3'd6, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL direct_sel6: got %h want %h", obs, {8'h16, 8'hE9, 1'b1, 3'd6, 1'b0, 1'b0});
        end
        cmp++;
        if (obs6 !== {8'h00, 8'hFF, 1'b0, 3'd3, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL direct6_sel6_err: got %h want %h", obs6, {8'h00, 8'hFF, 1'b0, 3'd3, 1'b0, 1'b1});
        end
    endtask

    task automatic test_strobe;
        strobe_n = 1;
        tick;
        cmp++;
        if (obs !== {8'h00, 8'hFF, 1'b0, 3'd6, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL strobe_idle: got %h want %h", obs, {8'h00, 8'hFF, 1'b0, 3'd6, 1'b0, 1'b0});
        end
        strobe_n = 0; sel = 3;
        tick;
        out_ready = 0; strobe_n = 1; sel = 5;
        for (int k = 0; k < 2; k++) begin
            tick;
            cmp++;
            if (obs !== {8'hA5, 8'h5A, 1'b1, 3'd3, 1'b0, 1'b0}) begin
                bad++;
                $display("FAIL strobe_held%0d: got %h want %h", k, obs, {8'hA5, 8'h5A, 1'b1, 3'd3, 1'b0, 1'b0});
            end
        end
        out_ready = 1;
        tick;
        cmp++;
        if (obs !== {8'h00, 8'hFF, 1'b0, 3'd3, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL strobe_release: got %h want %h", obs, {8'h00, 8'hFF, 1'b0, 3'd3, 1'b0, 1'b0});
        end
    endtask

    task automatic test_scan;
        int chs [5] = '{1, 4, 7, 1, 4};
        logic wraps [5] = '{0, 0, 0, 1, 0};
        strobe_n = 0; mode = 1; chan_en = 8'b1001_0010; out_ready = 1;
        for (int k = 0; k < 5; k++) begin
            tick;
            ey = 8'h10 + 8'(chs[k]);
            exp = {ey, ~ey, 1'b1, 3'(chs[k]), wraps[k], 1'b0};
            cmp++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL scan_step%0d: got %h want %h", k, obs, exp);
            end
        end
    endtask

    task automatic test_stall;
        int chs [4] = '{5, 6, 7, 0};
        logic wraps [4] = '{0, 0, 0, 1};
        out_ready = 0; chan_en = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            tick;
            cmp++;
            if (obs !== {8'h14, 8'hEB, 1'b1, 3'd4, 1'b0, 1'b0}) begin
                bad++;
                $display("FAIL stall_hold%0d: got %h want %h", k, obs, {8'h14, 8'hEB, 1'b1, 3'd4, 1'b0, 1'b0});
            end
        end
        out_ready = 1;
        for (int k = 0; k < 4; k++) begin
            tick;
            ey = 8'h10 + 8'(chs[k]);
            exp = {ey, ~ey, 1'b1, 3'(chs[k]), wraps[k], 1'b0};
            cmp++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL stall_resume%0d: got %h want %h", k, obs, exp);
            end
        end
    endtask

    task automatic test_single;
        logic wraps [3] = '{0, 1, 1};
        chan_en = 8'b0000_0100;
        for (int k = 0; k < 3; k++) begin
            tick;
            exp = {8'h12, 8'hED, 1'b1, 3'd2, wraps[k], 1'b0};
            cmp++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL single_ch%0d: got %h want %h", k, obs, exp);
            end
        end
    endtask

    task automatic test_boundary;
        int chs [3] = '{0, 5, 0};
        logic wraps [3] = '{0, 0, 1};
        mode = 0; sel = 7;
        for (int k = 0; k < 2; k++) begin
            tick;
            cmp++;
            if (obs6 !== {8'h00, 8'hFF, 1'b0, 3'd3, 1'b0, 1'b1}) begin
                bad++;
                $display("FAIL bound_sel7_%0d: got %h want %h", k, obs6, {8'h00, 8'hFF, 1'b0, 3'd3, 1'b0, 1'b1});
            end
        end
        sel = 2;
        tick;
        cmp++;
        if (obs6 !== {8'h62, 8'h9D, 1'b1, 3'd2, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL bound_sel2: got %h want %h", obs6, {8'h62, 8'h9D, 1'b1, 3'd2, 1'b0, 1'b0});
        end
        mode = 1; chanEn6 = 6'b000000;
        tick;
        cmp++;
        if (obs6 !== {8'h00, 8'hFF, 1'b0, 3'd2, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL bound_scan_none: got %h want %h", obs6, {8'h00, 8'hFF, 1'b0, 3'd2, 1'b0, 1'b0});
        end
        chanEn6 = 6'b100001;
        for (int k = 0; k < 3; k++) begin
            tick;
            ey = 8'h60 + 8'(chs[k]);
            exp = {ey, ~ey, 1'b1, 3'(chs[k]), wraps[k], 1'b0};
            cmp++;
            if (obs6 !== exp) begin
                bad++;
                $display("FAIL bound_scan6_%0d: got %h want %h", k, obs6, exp);
            end
        end
    endtask

    task automatic test_reset_mid;
        @(posedge clk);
        #3 reset = 1;
        #1;
        cmp++;
        if (obs !== {8'h00, 8'hFF, 1'b0, 3'd0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_mid: got %h want %h", obs, {8'h00, 8'hFF, 1'b0, 3'd0, 1'b0, 1'b0});
        end
        cmp++;
        if (obs6 !== {8'h00, 8'hFF, 1'b0, 3'd0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_mid6: got %h want %h", obs6, {8'h00, 8'hFF, 1'b0, 3'd0, 1'b0, 1'b0});
        end
        @(negedge clk) reset = 0;
        tick;
        cmp++;
        if (obs !== {8'h12, 8'hED, 1'b1, 3'd2, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_restart: got %h want %h", obs, {8'h12, 8'hED, 1'b1, 3'd2, 1'b0, 1'b0});
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) d[i*8 +: 8] = 8'h10 + 8'(i);
        d[24 +: 8] = 8'hA5;
        for (int i = 0; i < 6; i++) d6[i*8 +: 8] = 8'h60 + 8'(i);
        test_reset;
        test_direct;
        test_strobe;
        test_scan;
        test_stall;
        test_single;
        test_boundary;
        chan_en = 8'b0000_0100;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end
endmodule
